player_mover: RTL

PLAYER_MOVER -- requirements
Module: player_mover

---
 rtl/game_pkg.sv | 33 +++
 rtl/axis_stepper.sv | 125 ++++++++++++
 rtl/player_mover.sv | 66 ++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: game state encodings, the per-axis movement
// FSM states, and small elaboration-time helpers.
package game_pkg;

    // Game state encodings driven by the game controller.
    localparam logic [3:0] GS_RESET = 4'd0;
    localparam logic [3:0] GS_MENU  = 4'd1;
    localparam logic [3:0] GS_PLAY  = 4'd2;
    localparam logic [3:0] GS_OVER  = 4'd3;

    // Per-axis movement FSM.
    typedef enum logic [1:0] {
        AX_IDLE   = 2'd0,
        AX_HOLD   = 2'd1,
        AX_REPEAT = 2'd2
    } axis_state_t;

    // Counter width: wide enough for both the initial hold and the repeat
    // period, never zero.
    function automatic int cnt_width(input int first_cyc, input int repeat_cyc);
        int w;
        w = $clog2(first_cyc);
        if ($clog2(repeat_cyc) > w) w = $clog2(repeat_cyc);
        if (w < 1) w = 1;
        return w;
    endfunction

    // Periods shorter than one cycle are not meaningful.
    function automatic int min1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/axis_stepper.sv
// One movement axis: press/hold/auto-repeat FSM, step counter and a
// clamped position register. Instantiated once per axis.
module axis_stepper
    import game_pkg::*;
#(
    parameter int POS_W      = 7,
    parameter int MAX        = 79,
    parameter int INIT       = 40,
    parameter int FIRST_CYC  = 3333334,
    parameter int REPEAT_CYC = 1666667,
    parameter int DASH_SHIFT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_enable,
    input  logic             i_respawn,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_dash,
    output logic [POS_W-1:0] o_pos,
    output logic             o_moved,
    output axis_state_t      o_state
);

    localparam int CNT_W  = cnt_width(FIRST_CYC, REPEAT_CYC);
    localparam int P_NORM = min1(REPEAT_CYC);
    localparam int P_DASH = min1(REPEAT_CYC >> DASH_SHIFT);

    localparam logic [CNT_W-1:0] LIM_FIRST = CNT_W'(FIRST_CYC - 1);
    localparam logic [CNT_W-1:0] LIM_NORM  = CNT_W'(P_NORM - 1);
    localparam logic [CNT_W-1:0] LIM_DASH  = CNT_W'(P_DASH - 1);
    localparam logic [POS_W-1:0] POS_MAX   = POS_W'(MAX);
    localparam logic [POS_W-1:0] POS_INIT  = POS_W'(INIT);

    axis_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir;
    logic [POS_W-1:0] r_pos;
    logic             r_moved;

    axis_state_t      w_state_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             w_dir_nx;
    logic             w_step;
    logic             w_req;
    logic             w_can;
    logic [CNT_W-1:0] w_lim;

    // Exactly one button of the pair forms a request; i_inc selects direction.
    // The repeat limit follows dash live so a mid-period change acts at once.
    assign w_req = i_inc ^ i_dec;
    assign w_lim = i_dash ? LIM_DASH : LIM_NORM;
    assign w_can = i_inc ? (r_pos < POS_MAX) : (r_pos != '0);

    // Next-state, counter and step decision for the press/hold/repeat FSM.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_dir_nx   = r_dir;
        w_step     = 1'b0;
        if (!i_enable || !w_req) begin
            w_state_nx = AX_IDLE;
            w_cnt_nx   = '0;
        end else if (r_state == AX_IDLE || i_inc != r_dir) begin
            // Fresh press or direction reversal: step now, restart the hold.
            w_step     = 1'b1;
            w_cnt_nx   = '0;
            w_state_nx = AX_HOLD;
            w_dir_nx   = i_inc;
        end else begin
            case (r_state)
                AX_HOLD: begin
                    if (r_cnt == LIM_FIRST) begin
                        w_step     = 1'b1;
                        w_cnt_nx   = '0;
                        w_state_nx = AX_REPEAT;
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end
                AX_REPEAT: begin
                    if (r_cnt >= w_lim) begin
                        w_step   = 1'b1;
                        w_cnt_nx = '0;
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nx = AX_IDLE;
                    w_cnt_nx   = '0;
                end
            endcase
        end
    end

    // State, counter and clamped position update; respawn overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= AX_IDLE;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_pos   <= POS_INIT;
            r_moved <= 1'b0;
        end else if (i_respawn) begin
            r_state <= AX_IDLE;
            r_cnt   <= '0;
            r_pos   <= POS_INIT;
            r_moved <= (r_pos != POS_INIT);
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_dir   <= w_dir_nx;
            r_moved <= w_step && w_can;
            if (w_step && w_can) begin
                r_pos <= i_inc ? (r_pos + POS_W'(1)) : (r_pos - POS_W'(1));
            end
        end
    end

    assign o_pos   = r_pos;
    assign o_moved = r_moved;
    assign o_state = r_state;

endmodule

// File: rtl/player_mover.sv
// Player position controller: two independent axis steppers driven by the
// direction buttons, gated by the game state, with a respawn override.
module player_mover
    import game_pkg::*;
#(
    parameter int         POS_W      = 7,
    parameter int         X_MAX      = 79,
    parameter int         Y_MAX      = 59,
    parameter int         X_INIT     = 40,
    parameter int         Y_INIT     = 30,
    parameter int         FIRST_CYC  = 3333334,
    parameter int         REPEAT_CYC = 1666667,
    parameter int         DASH_SHIFT = 1,
    parameter logic [3:0] PLAY_STATE = GS_PLAY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       state,
    input  logic             up,
    input  logic             down,
    input  logic             left,
    input  logic             right,
    input  logic             dash,
    input  logic             respawn,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    output logic             moved,
    output logic [3:0]       at_edge,
    output logic [1:0]       dbg_x_state,
    output logic [1:0]       dbg_y_state
);

    logic        w_enable;
    logic        w_x_moved;
    logic        w_y_moved;
    axis_state_t w_x_state;
    axis_state_t w_y_state;

    assign w_enable = (state == PLAY_STATE);

    axis_stepper #(
        .POS_W(POS_W), .MAX(X_MAX), .INIT(X_INIT),
        .FIRST_CYC(FIRST_CYC), .REPEAT_CYC(REPEAT_CYC), .DASH_SHIFT(DASH_SHIFT)
    ) u_x (
        .clk(clk), .rst_n(rst_n), .i_enable(w_enable), .i_respawn(respawn),
        .i_inc(right), .i_dec(left), .i_dash(dash),
        .o_pos(pos_x), .o_moved(w_x_moved), .o_state(w_x_state)
    );

    axis_stepper #(
        .POS_W(POS_W), .MAX(Y_MAX), .INIT(Y_INIT),
        .FIRST_CYC(FIRST_CYC), .REPEAT_CYC(REPEAT_CYC), .DASH_SHIFT(DASH_SHIFT)
    ) u_y (
        .clk(clk), .rst_n(rst_n), .i_enable(w_enable), .i_respawn(respawn),
        .i_inc(up), .i_dec(down), .i_dash(dash),
        .o_pos(pos_y), .o_moved(w_y_moved), .o_state(w_y_state)
    );

    // A diagonal step still gives a single moved pulse.
    assign moved       = w_x_moved | w_y_moved;
    assign at_edge     = {pos_x == '0, pos_x == POS_W'(X_MAX),
                          pos_y == '0, pos_y == POS_W'(Y_MAX)};
    assign dbg_x_state = w_x_state;
    assign dbg_y_state = w_y_state;

endmodule
